zx_mem_pager: RTL and testbench

- Parametrised successor to the fixed top-level write-protect router: a Spectrum-128-style memory pager sitting between the Z80 core and the dual-port `memory` block.
- Translates the 16-bit CPU address into a physical page/offset address, gates write enables per page type, and latches the paging and border I/O ports.
- Supplies the physical address for the ULA video port, including shadow-screen selection.
- Scales from 128K (8 banks) to 1M (64 banks) through an extended paging port.

---
 rtl/zx_mem_pager_if.sv | 27 ++
 rtl/zx_mem_pager.sv | 115 +++++++++++
 tb/tb_zx_mem_pager.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/zx_mem_pager_if.sv
// CPU/ULA-side bus of the memory pager: CPU address/data/strobes in, translated
// addresses, write enable and latched I/O port state out.
interface zx_mem_pager_if #(
  parameter int PAGE_W = 4
);
  logic [15:0]        address;
  logic [7:0]         data;
  logic               wren_cpu;
  logic               io_wr;
  logic [12:0]        video_addr;
  logic [PAGE_W+13:0] phys_addr;
  logic               wren;
  logic [PAGE_W+13:0] video_phys;
  logic [2:0]         border;
  logic               speaker;
  logic               lock;

  modport master (
    output address, data, wren_cpu, io_wr, video_addr,
    input  phys_addr, wren, video_phys, border, speaker, lock
  );

  modport slave (
    input  address, data, wren_cpu, io_wr, video_addr,
    output phys_addr, wren, video_phys, border, speaker, lock
  );
endinterface

// File: rtl/zx_mem_pager.sv
// Spectrum-128-style memory pager: maps the CPU address onto physical RAM/ROM
// pages, blocks ROM writes, latches the paging/border ports, and addresses the ULA screen.
module zx_mem_pager #(
  parameter int          BANK_W   = 3,
  parameter int          ROM_W    = 1,
  parameter logic [15:0] EXT_PORT = 16'hDFFD,
  parameter int          PAGE_W   = BANK_W + 1
) (
  input  logic           clock,
  input  logic           reset,
  zx_mem_pager_if.slave  bus
);

  logic              io_wr_d;
  logic              strobe;
  logic              fe_hit;
  logic              pg_hit;
  logic [2:0]        border_q;
  logic              speaker_q;
  logic              lock_q;
  logic [2:0]        ram_sel;
  logic              scr_sel;
  logic              rom_lo;
  logic [ROM_W-1:0]  rom_sel;
  logic [BANK_W-1:0] bank_hi;
  logic [BANK_W-1:0] scr_bank;
  logic [PAGE_W-1:0] page;
  logic              unused_data;

  assign strobe = bus.io_wr & ~io_wr_d;
  assign fe_hit = ~bus.address[0];
  assign pg_hit = ~bus.address[15] & ~bus.address[1];

  // io_wr_d resets high so a strobe already asserted out of reset is ignored
  always_ff @(posedge clock) begin
    if (reset) begin
      io_wr_d   <= 1'b1;
      border_q  <= 3'd0;
      speaker_q <= 1'b0;
      lock_q    <= 1'b0;
      ram_sel   <= 3'd0;
      scr_sel   <= 1'b0;
      rom_lo    <= 1'b0;
    end else begin
      io_wr_d <= bus.io_wr;
      if (strobe && fe_hit) begin
        border_q  <= bus.data[2:0];
        speaker_q <= bus.data[4];
      end
      if (strobe && pg_hit && !lock_q) begin
        ram_sel <= bus.data[2:0];
        scr_sel <= bus.data[3];
        rom_lo  <= bus.data[4];
        lock_q  <= bus.data[5];
      end
    end
  end

  generate
    if (BANK_W > 3) begin : g_ext
      logic [BANK_W-4:0] ext_sel;
      logic              ext_wr;

      assign ext_wr = strobe & ~lock_q & (bus.address == EXT_PORT);

      always_ff @(posedge clock) begin
        if (reset) ext_sel <= '0;
        else if (ext_wr) ext_sel <= bus.data[BANK_W-4:0];
      end

      assign bank_hi = {ext_sel, ram_sel};

      if (ROM_W == 2) begin : g_rom_hi
        logic rom_hi;
        always_ff @(posedge clock) begin
          if (reset) rom_hi <= 1'b0;
          else if (ext_wr) rom_hi <= bus.data[BANK_W-3];
        end
        assign rom_sel = {rom_hi, rom_lo};
      end else begin : g_rom_lo
        assign rom_sel = rom_lo;
      end
    end else begin : g_noext
      // Without the extended port the upper ROM select bit cannot be written
      assign bank_hi = ram_sel;
      if (ROM_W == 2) begin : g_rom_hi
        assign rom_sel = {1'b0, rom_lo};
      end else begin : g_rom_lo
        assign rom_sel = rom_lo;
      end
    end
  endgenerate

  always_comb begin
    page = '0;
    case (bus.address[15:14])
      2'b00:   page = {1'b1, {(BANK_W-ROM_W){1'b0}}, rom_sel};
      2'b01:   page = {1'b0, BANK_W'(5)};
      2'b10:   page = {1'b0, BANK_W'(2)};
      default: page = {1'b0, bank_hi};
    endcase
  end

  assign scr_bank       = scr_sel ? BANK_W'(7) : BANK_W'(5);
  assign bus.phys_addr  = {page, bus.address[13:0]};
  assign bus.wren       = bus.wren_cpu & ~page[PAGE_W-1];
  assign bus.video_phys = {1'b0, scr_bank, 1'b0, bus.video_addr};
  assign bus.border     = border_q;
  assign bus.speaker    = speaker_q;
  assign bus.lock       = lock_q;

  // data[7:6] carry no meaning on either port
  assign unused_data = &{1'b0, bus.data[7:6]};

endmodule

// File: tb/tb_zx_mem_pager.sv
// Drives a 128K (BANK_W=3, ROM_W=1) and a 1M (BANK_W=6, ROM_W=2) pager with the same
// stimulus; an arithmetic reference model feeds a scoreboard checked every cycle.
module tb_zx_mem_pager;

  typedef struct {
    logic [17:0] s_phys;
    logic        s_wren;
    logic [17:0] s_vid;
    logic [20:0] b_phys;
    logic        b_wren;
    logic [20:0] b_vid;
    logic [2:0]  border;
    logic        spk;
    logic        lock;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];

  // reference model state
  int m_ram, m_scr, m_rom0, m_rom1, m_ext, m_lock, m_border, m_spk, m_iod;
  bit m_valid = 1'b0;

  zx_mem_pager_if #(.PAGE_W(4)) bs ();
  zx_mem_pager_if #(.PAGE_W(7)) bb ();

  zx_mem_pager #(.BANK_W(3), .ROM_W(1), .EXT_PORT(16'hDFFD)) dut_s (
    .clock (clock),
    .reset (reset),
    .bus   (bs)
  );

  zx_mem_pager #(.BANK_W(6), .ROM_W(2), .EXT_PORT(16'hDFFD)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bb)
  );

  always #5 clock = ~clock;

  function automatic exp_t predict(input int addr, input bit wc, input int va);
    exp_t e;
    int win, off, ps, pb, vb;
    win = addr / 16384;
    off = addr % 16384;
    case (win)
      0:       begin ps = 8 + m_rom0;  pb = 64 + m_rom1 * 2 + m_rom0; end
      1:       begin ps = 5;           pb = 5;                        end
      2:       begin ps = 2;           pb = 2;                        end
      default: begin ps = m_ram;       pb = m_ext * 8 + m_ram;        end
    endcase
    vb = m_scr ? 7 : 5;
    e.s_phys = 18'(ps * 16384 + off);
    e.b_phys = 21'(pb * 16384 + off);
    e.s_wren = wc && (win != 0);
    e.b_wren = wc && (win != 0);
    e.s_vid  = 18'(vb * 16384 + va);
    e.b_vid  = 21'(vb * 16384 + va);
    e.border = 3'(m_border);
    e.spk    = m_spk[0];
    e.lock   = m_lock[0];
    return e;
  endfunction

  task automatic model_step(input bit rst, input bit io, input int addr, input int dat);
    int was_locked;
    if (rst) begin
      m_ram = 0; m_scr = 0; m_rom0 = 0; m_rom1 = 0; m_ext = 0;
      m_lock = 0; m_border = 0; m_spk = 0; m_iod = 1;
      m_valid = 1'b1;
    end else begin
      if (io && m_iod == 0) begin
        was_locked = m_lock;
        if (addr % 2 == 0) begin
          m_border = dat % 8;
          m_spk    = (dat / 16) % 2;
        end
        if (addr < 32768 && (addr / 2) % 2 == 0 && was_locked == 0) begin
          m_ram  = dat % 8;
          m_scr  = (dat / 8) % 2;
          m_rom0 = (dat / 16) % 2;
          m_lock = (dat / 32) % 2;
        end
        if (addr == 'hDFFD && was_locked == 0) begin
          m_ext  = dat % 8;
          m_rom1 = (dat / 8) % 2;
        end
      end
      m_iod = io ? 1 : 0;
    end
  endtask

  // One clock: apply inputs, queue the expected outputs for this cycle, then advance the model
  task automatic cyc(input bit rst, input bit io, input logic [15:0] a, input logic [7:0] d,
                     input bit wc);
    logic [12:0] va;
    va = 13'($urandom);
    reset = rst;
    bs.address = a; bs.data = d; bs.io_wr = io; bs.wren_cpu = wc; bs.video_addr = va;
    bb.address = a; bb.data = d; bb.io_wr = io; bb.wren_cpu = wc; bb.video_addr = va;
    if (m_valid) sb.push_back(predict(int'(a), wc, int'(va)));
    @(posedge clock);
    model_step(rst, io, int'(a), int'(d));
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b1, a, d, 1'b0);
    cyc(1'b0, 1'b0, a, d, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("s_phys_addr",  32'(bs.phys_addr),  32'(e.s_phys));
      chk("s_wren",       32'(bs.wren),       32'(e.s_wren));
      chk("s_video_phys", 32'(bs.video_phys), 32'(e.s_vid));
      chk("s_border",     32'(bs.border),     32'(e.border));
      chk("s_speaker",    32'(bs.speaker),    32'(e.spk));
      chk("s_lock",       32'(bs.lock),       32'(e.lock));
      chk("b_phys_addr",  32'(bb.phys_addr),  32'(e.b_phys));
      chk("b_wren",       32'(bb.wren),       32'(e.b_wren));
      chk("b_video_phys", 32'(bb.video_phys), 32'(e.b_vid));
      chk("b_border",     32'(bb.border),     32'(e.border));
      chk("b_speaker",    32'(bb.speaker),    32'(e.spk));
      chk("b_lock",       32'(bb.lock),       32'(e.lock));
    end
  end

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    bit          io;

    // reset defaults
    cyc(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 16'hC123, 8'h00, 1'b0);

    // held strobe acts once; data change mid-strobe is ignored
    cyc(1'b0, 1'b1, 16'h7FFD, 8'h17, 1'b0);
    cyc(1'b0, 1'b1, 16'h7FFD, 8'h17, 1'b0);
    cyc(1'b0, 1'b1, 16'h7FFD, 8'h02, 1'b0);
    cyc(1'b0, 1'b1, 16'h7FFD, 8'h02, 1'b0);
    cyc(1'b0, 1'b0, 16'hC000, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);

    // lock blocks paging and the extended port but not the border port
    wr(16'h7FFD, 8'h23);
    wr(16'h7FFD, 8'h04);
    wr(16'hDFFD, 8'h0F);
    wr(16'h00FE, 8'h15);
    cyc(1'b0, 1'b0, 16'hC000, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 16'hC000, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 16'hC000, 8'h00, 1'b0);

    // ROM writes are dropped, RAM writes pass
    cyc(1'b0, 1'b0, 16'h1234, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 16'h8000, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 16'h4000, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 16'hFFFF, 8'h00, 1'b1);

    // extended bank port
    wr(16'hDFFD, 8'h05);
    wr(16'h7FFD, 8'h06);
    cyc(1'b0, 1'b0, 16'hC000, 8'h00, 1'b0);
    wr(16'hDFFD, 8'h0D);
    cyc(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 16'hFABC, 8'h00, 1'b0);

    // overlapping FE and 7FFD decodes
    wr(16'h7FFC, 8'h0A);
    cyc(1'b0, 1'b0, 16'hC000, 8'h00, 1'b0);

    // reset coincident with a strobe edge, strobe held across reset release
    wr(16'h7FFC, 8'h1F);
    cyc(1'b1, 1'b1, 16'h7FFC, 8'h3F, 1'b0);
    cyc(1'b0, 1'b1, 16'h7FFC, 8'h3F, 1'b0);
    cyc(1'b0, 1'b1, 16'hC000, 8'h3F, 1'b0);
    cyc(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 6))
        0:       a = 16'h7FFD;
        1:       a = 16'hDFFD;
        2:       a = 16'h00FE;
        3:       a = 16'h7FFC;
        4:       a = 16'h3FFD;
        default: a = 16'($urandom);
      endcase
      d  = 8'($urandom);
      io = ($urandom_range(0, 2) == 0);
      cyc(($urandom_range(0, 39) == 0), io, a, d, 1'($urandom));
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
